urng_pair_framer: RTL and testbench
===================================

Name: urng_pair_framer

Overview:
- Sits directly downstream of the 32-bit Tausworthe URNG in the AWGN generator datapath.
- Collects consecutive 32-bit uniform words into pairs and repacks each pair into a 48-bit u0 and a 16-bit u1 operand, as consumed by the Box-Muller stage.
- Buffers completed pairs in a small show-ahead FIFO with a valid/ready output handshake.
- The URNG cannot be stalled, so pairs that arrive while the FIFO is full are dropped and counted.

Parameters:
- DEPTH, 4, FIFO depth in pairs; power of two, ≥2.
- DROP_W, 16, width of the saturating drop counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- urng_in  input  32  uniform word from the URNG.
- urng_valid  input  1  urng_in carries a new word this cycle.
- flush  input  1  synchronous clear of FIFO and pair phase.
- out_u0  output  48  u0 of head pair.
- out_u1  output  16  u1 of head pair.
- out_valid  output  1  head pair valid.
- out_ready  input  1  consumer accepts head pair.
- fifo_level  output  $clog2(DEPTH)+1  number of stored pairs.
- drop_count  output  DROP_W  number of pairs lost to a full FIFO; saturating.

Behaviour:
- Reset (async): phase=0, FIFO empty, fifo_level=0, out_valid=0, out_u0=0, out_u1=0, drop_count=0.
- Phase bit, first word (phase 0, urng_valid=1): latch hi_word=urng_in, then phase←1.
- Phase bit, second word (phase 1, urng_valid=1): form u0={hi_word, urng_in[31:16]} and u1=urng_in[15:0]. This is a pair-complete event; phase←0.
- urng_valid=0: phase and hi_word hold. There is no timeout on a half-built pair.
- Push on pair-complete if the FIFO is not full, or if it is full and a pop occurs in the same cycle. In the full+pop case both happen and level is unchanged.
- Otherwise the pair is dropped: drop_count increments, saturating at 2^DROP_W-1. Phase still returns to 0.
- Pop: occurs when out_valid && out_ready.
- Show-ahead output: out_valid=(level!=0). out_u0/out_u1 always show the head entry and are held stable while out_valid && !out_ready.
- When empty: out_u0/out_u1 hold their last popped value (0 after reset). They carry no meaning while out_valid=0.
- Latency: a pair completed at edge N into an empty FIFO gives out_valid=1 and data visible after edge N, i.e. usable in cycle N+1. There is no pass-through in the same cycle.
- Simultaneous push+pop on an empty FIFO: impossible, since pop requires out_valid.
- Simultaneous push+pop on a non-empty, non-full FIFO: level unchanged, order preserved.
- Read/write pointers are $clog2(DEPTH) bits and wrap naturally. fifo_level is tracked separately in the range 0..DEPTH.
- flush=1:
  - empties the FIFO and sets phase←0, discarding any half pair;
  - takes priority over push/pop in that cycle;
  - leaves drop_count unchanged;
  - does not count the discarded half pair or any word arriving that cycle as a drop.
- Reset mid-pair: hi_word is discarded and the next valid word is treated as a first word.
- Pair order out equals pair order in; no reordering or duplication.

Test Plan:
- Basic pairing: out_ready=1, urng_valid=1 with 0xAAAA5555 then 0x12345678. Required: cycle after second word, out_valid=1, out_u0=0xAAAA55551234, out_u1=0x5678; next cycle out_valid=0.
- Gapped input: 0x0000FFFF, two idle cycles with urng_valid=0, then 0xDEADBEEF. Required: single pair u0=0x0000FFFFDEAD, u1=0xBEEF; no spurious output during the gap.
- Overflow: out_ready=0, 10 consecutive words (pairs P0..P4), DEPTH=4. Required: fifo_level=4, drop_count=1. Then out_ready=1 yields P0..P3 in order and P4 never appears.
- Full push+pop: with FIFO full, assert out_ready=1 in the same cycle a pair completes. Required: drop_count unchanged, fifo_level stays 4, the new pair emerges after the three older pairs.
- Saturation: DROP_W=2, FIFO full, 6 dropped pairs. Required: drop_count reaches 3 and stays 3.
- Reset/flush mid-pair:
  - Send 0x11111111, then assert reset for 1 cycle, then send 0x22222222 and 0x33333333. Required: output u0=0x222222223333, u1=0x3333.
  - Repeat using flush instead of reset, with 2 pairs queued. Required: fifo_level=0 after flush, drop_count unchanged.

Source files
------------

// File: rtl/urng_pair_framer.sv
// Pairs consecutive 32-bit URNG words into 48-bit u0 / 16-bit u1 Box-Muller operands
// and queues them in a show-ahead FIFO. Pairs that arrive while the FIFO is full are dropped and counted.
module urng_pair_framer #(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             urng_in,
  input  logic                    urng_valid,
  input  logic                    flush,
  output logic [47:0]             out_u0,
  output logic [15:0]             out_u1,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic [DROP_W-1:0]       drop_count
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [47:0] u0;
    logic [15:0] u1;
  } pair_t;

  typedef enum logic {PH_FIRST, PH_SECOND} phase_e;

  phase_e      phase, phase_nxt;
  logic [31:0] hi_word, hi_word_nxt;
  logic        pair_done;
  pair_t       pair_new;

  pair_t           mem [DEPTH];
  pair_t           head, last;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [PW:0]     level;
  logic            full, push, pop, drop;

  // ---------------- pair assembly ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase   <= PH_FIRST;
      hi_word <= '0;
    end else begin
      phase   <= phase_nxt;
      hi_word <= hi_word_nxt;
    end
  end

  always_comb begin
    phase_nxt   = phase;
    hi_word_nxt = hi_word;
    pair_done   = 1'b0;
    pair_new.u0 = {hi_word, urng_in[31:16]};
    pair_new.u1 = urng_in[15:0];
    // flush discards a half-built pair and any word arriving alongside it
    if (flush) begin
      phase_nxt = PH_FIRST;
    end else if (urng_valid) begin
      case (phase)
        PH_FIRST: begin
          hi_word_nxt = urng_in;
          phase_nxt   = PH_SECOND;
        end
        PH_SECOND: begin
          pair_done = 1'b1;
          phase_nxt = PH_FIRST;
        end
        default: phase_nxt = PH_FIRST;
      endcase
    end
  end

  // ---------------- show-ahead FIFO ----------------
  assign full      = (level == (PW+1)'(DEPTH));
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready && !flush;
  // a full FIFO still accepts a pair when the head leaves in the same cycle
  assign push      = pair_done && (!full || pop);
  assign drop      = pair_done && full && !pop;

  assign head   = mem[rd_ptr];
  assign out_u0 = out_valid ? head.u0 : last.u0;
  assign out_u1 = out_valid ? head.u1 : last.u1;
  assign fifo_level = level;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pair_new;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      last   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        last   <= head;
      end
      level <= level + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // ---------------- saturating drop counter ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      drop_count <= '0;
    else if (drop && (drop_count != '1))
      drop_count <= drop_count + DROP_W'(1);
  end

endmodule

// File: tb/tb_urng_pair_framer.sv
// Directed bench for urng_pair_framer: table-driven per-cycle vectors plus hand-written
// saturation, flush and reset sequences. A second instance with DROP_W=2 checks counter saturation.
module tb_urng_pair_framer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] urng_in = '0;
  logic        urng_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic [47:0] out_u0, s_u0;
  logic [15:0] out_u1, s_u1;
  logic        out_valid, s_valid;
  logic [2:0]  fifo_level, s_level;
  logic [15:0] drop_count;
  logic [1:0]  s_drop;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  urng_pair_framer #(.DEPTH(4), .DROP_W(16)) dut (
    .clk(clk), .reset(reset), .urng_in(urng_in), .urng_valid(urng_valid), .flush(flush),
    .out_u0(out_u0), .out_u1(out_u1), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .drop_count(drop_count));

  urng_pair_framer #(.DEPTH(4), .DROP_W(2)) dut_s (
    .clk(clk), .reset(reset), .urng_in(urng_in), .urng_valid(urng_valid), .flush(flush),
    .out_u0(s_u0), .out_u1(s_u1), .out_valid(s_valid), .out_ready(out_ready),
    .fifo_level(s_level), .drop_count(s_drop));

  typedef struct {
    logic        v;
    logic [31:0] w;
    logic        rdy;
    logic        ev;
    logic [47:0] eu0;
    logic [15:0] eu1;
    int          elvl;
    int          edrop;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [31:0] w, logic rdy, logic ev,
                              logic [47:0] eu0, logic [15:0] eu1, int elvl, int edrop);
    vec_t r;
    r.v = v; r.w = w; r.rdy = rdy; r.ev = ev;
    r.eu0 = eu0; r.eu1 = eu1; r.elvl = elvl; r.edrop = edrop;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] w, input logic rdy, input logic fl);
    urng_valid = v; urng_in = w; out_ready = rdy; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string name, input logic ev, input logic [47:0] eu0,
                           input logic [15:0] eu1, input int elvl, input int edrop, input int esdrop);
    chk({name, "/valid"}, 64'(out_valid), 64'(ev));
    if (ev) begin
      chk({name, "/u0"}, 64'(out_u0), 64'(eu0));
      chk({name, "/u1"}, 64'(out_u1), 64'(eu1));
    end
    chk({name, "/level"}, 64'(fifo_level), 64'(elvl));
    chk({name, "/drop"}, 64'(drop_count), 64'(edrop));
    chk({name, "/s_level"}, 64'(s_level), 64'(elvl));
    chk({name, "/s_drop"}, 64'(s_drop), 64'(esdrop));
  endtask

  initial begin
    // basic pairing
    tbl.push_back(mk(1, 32'hAAAA5555, 1, 0, 48'h0, 16'h0, 0, 0));
    tbl.push_back(mk(1, 32'h12345678, 1, 1, 48'hAAAA55551234, 16'h5678, 1, 0));
    tbl.push_back(mk(0, 32'h0,        1, 0, 48'h0, 16'h0, 0, 0));
    // gapped input
    tbl.push_back(mk(1, 32'h0000FFFF, 1, 0, 48'h0, 16'h0, 0, 0));
    tbl.push_back(mk(0, 32'h0,        1, 0, 48'h0, 16'h0, 0, 0));
    tbl.push_back(mk(0, 32'h0,        1, 0, 48'h0, 16'h0, 0, 0));
    tbl.push_back(mk(1, 32'hDEADBEEF, 1, 1, 48'h0000FFFFDEAD, 16'hBEEF, 1, 0));
    tbl.push_back(mk(0, 32'h0,        1, 0, 48'h0, 16'h0, 0, 0));
    // overflow: five pairs into a depth-4 FIFO with the consumer stalled
    tbl.push_back(mk(1, 32'h11111111, 0, 0, 48'h0, 16'h0, 0, 0));
    tbl.push_back(mk(1, 32'hC000D000, 0, 1, 48'h11111111C000, 16'hD000, 1, 0));
    tbl.push_back(mk(1, 32'h22222222, 0, 1, 48'h11111111C000, 16'hD000, 1, 0));
    tbl.push_back(mk(1, 32'hC001D001, 0, 1, 48'h11111111C000, 16'hD000, 2, 0));
    tbl.push_back(mk(1, 32'h33333333, 0, 1, 48'h11111111C000, 16'hD000, 2, 0));
    tbl.push_back(mk(1, 32'hC002D002, 0, 1, 48'h11111111C000, 16'hD000, 3, 0));
    tbl.push_back(mk(1, 32'h44444444, 0, 1, 48'h11111111C000, 16'hD000, 3, 0));
    tbl.push_back(mk(1, 32'hC003D003, 0, 1, 48'h11111111C000, 16'hD000, 4, 0));
    tbl.push_back(mk(1, 32'h55555555, 0, 1, 48'h11111111C000, 16'hD000, 4, 0));
    tbl.push_back(mk(1, 32'hC004D004, 0, 1, 48'h11111111C000, 16'hD000, 4, 1));
    tbl.push_back(mk(0, 32'h0,        1, 1, 48'h22222222C001, 16'hD001, 3, 1));
    tbl.push_back(mk(0, 32'h0,        1, 1, 48'h33333333C002, 16'hD002, 2, 1));
    tbl.push_back(mk(0, 32'h0,        1, 1, 48'h44444444C003, 16'hD003, 1, 1));
    tbl.push_back(mk(0, 32'h0,        1, 0, 48'h0, 16'h0, 0, 1));
    // full FIFO with push and pop in the same cycle
    tbl.push_back(mk(1, 32'h60000000, 0, 0, 48'h0, 16'h0, 0, 1));
    tbl.push_back(mk(1, 32'hF0009000, 0, 1, 48'h60000000F000, 16'h9000, 1, 1));
    tbl.push_back(mk(1, 32'h60000001, 0, 1, 48'h60000000F000, 16'h9000, 1, 1));
    tbl.push_back(mk(1, 32'hF0019001, 0, 1, 48'h60000000F000, 16'h9000, 2, 1));
    tbl.push_back(mk(1, 32'h60000002, 0, 1, 48'h60000000F000, 16'h9000, 2, 1));
    tbl.push_back(mk(1, 32'hF0029002, 0, 1, 48'h60000000F000, 16'h9000, 3, 1));
    tbl.push_back(mk(1, 32'h60000003, 0, 1, 48'h60000000F000, 16'h9000, 3, 1));
    tbl.push_back(mk(1, 32'hF0039003, 0, 1, 48'h60000000F000, 16'h9000, 4, 1));
    tbl.push_back(mk(1, 32'h60000004, 0, 1, 48'h60000000F000, 16'h9000, 4, 1));
    tbl.push_back(mk(1, 32'hF0049004, 1, 1, 48'h60000001F001, 16'h9001, 4, 1));
    tbl.push_back(mk(0, 32'h0,        1, 1, 48'h60000002F002, 16'h9002, 3, 1));
    tbl.push_back(mk(0, 32'h0,        1, 1, 48'h60000003F003, 16'h9003, 2, 1));
    tbl.push_back(mk(0, 32'h0,        1, 1, 48'h60000004F004, 16'h9004, 1, 1));
    tbl.push_back(mk(0, 32'h0,        1, 0, 48'h0, 16'h0, 0, 1));

    // reset state
    #12;
    chk("rst/valid", 64'(out_valid), 64'(0));
    chk("rst/u0", 64'(out_u0), 64'(0));
    chk("rst/u1", 64'(out_u1), 64'(0));
    chk("rst/level", 64'(fifo_level), 64'(0));
    chk("rst/drop", 64'(drop_count), 64'(0));
    chk("rst/s_drop", 64'(s_drop), 64'(0));
    reset = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].w, tbl[i].rdy, 1'b0);
      chk_state($sformatf("vec%0d", i), tbl[i].ev, tbl[i].eu0, tbl[i].eu1,
                tbl[i].elvl, tbl[i].edrop, tbl[i].edrop);
    end

    // saturation: fill, then six more pairs are dropped
    for (int p = 0; p < 4; p++) begin
      step(1'b1, 32'h70000000 + 32'(p), 1'b0, 1'b0);
      step(1'b1, 32'h71000000 + 32'(p), 1'b0, 1'b0);
    end
    chk_state("sat_fill", 1'b1, 48'h700000007100, 16'h0000, 4, 1, 1);
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, 32'h7A000000 + 32'(k), 1'b0, 1'b0);
      step(1'b1, 32'h7B000000 + 32'(k), 1'b0, 1'b0);
      chk_state($sformatf("sat%0d", k), 1'b1, 48'h700000007100, 16'h0000,
                4, 1 + k, (1 + k > 3) ? 3 : 1 + k);
    end

    // flush mid-pair with two pairs queued
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk_state("pre_flush", 1'b1, 48'h700000027100, 16'h0002, 2, 7, 3);
    step(1'b1, 32'h77777777, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk_state("flush", 1'b0, 48'h0, 16'h0, 0, 7, 3);
    step(1'b1, 32'h9999AAAA, 1'b0, 1'b0);
    step(1'b1, 32'hBBBBCCCC, 1'b0, 1'b0);
    chk_state("post_flush", 1'b1, 48'h9999AAAABBBB, 16'hCCCC, 1, 7, 3);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    // flush while the completing word arrives: neither pushed nor dropped
    step(1'b1, 32'h12121212, 1'b0, 1'b0);
    step(1'b1, 32'h34343434, 1'b0, 1'b1);
    chk_state("flush_word", 1'b0, 48'h0, 16'h0, 0, 7, 3);
    step(1'b1, 32'h56565656, 1'b0, 1'b0);
    step(1'b1, 32'h78787878, 1'b0, 1'b0);
    chk_state("post_flush2", 1'b1, 48'h565656567878, 16'h7878, 1, 7, 3);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // reset mid-pair
    step(1'b1, 32'h11111111, 1'b0, 1'b0);
    reset = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("rst2/u0", 64'(out_u0), 64'(0));
    chk("rst2/u1", 64'(out_u1), 64'(0));
    chk_state("rst2", 1'b0, 48'h0, 16'h0, 0, 0, 0);
    reset = 1'b0;
    step(1'b1, 32'h22222222, 1'b0, 1'b0);
    chk_state("rst2_first", 1'b0, 48'h0, 16'h0, 0, 0, 0);
    step(1'b1, 32'h33333333, 1'b0, 1'b0);
    chk_state("rst2_pair", 1'b1, 48'h222222223333, 16'h3333, 1, 0, 0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk_state("rst2_pop", 1'b0, 48'h0, 16'h0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
